// File: rtl/booth_pkg.sv
// Purpose: shared types and sizing for the Booth multiplier operand issuer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

    localparam int BOOTH_WIDTH      = 32;
    localparam int BOOTH_MUL_CYCLES = 33;
    localparam int BOOTH_TAG_W      = 4;

    // IDLE: nothing issued; LOAD: load pulse on the wire; WAIT: multiplier
    // iterating; HOLD: product presented on the result stream.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } issuer_state_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Purpose: 2-entry register FIFO holding packed {tag, a, b} operand entries.
// Latency: a pushed entry is visible at head_dat the edge after the push.
// Backpressure: push refused while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports: clk/rst_a (async active-low), push_vld/push_dat write side,
//        pop/head_dat read side, count/full/empty occupancy flags.
module booth_op_fifo #(
    parameter int DW = 68
) (
    input  logic          clk,
    input  logic          rst_a,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [1:0]    count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          do_push, do_pop;

    // Flags come from the registered count only, so "full" refuses a push
    // even when the head is being popped in the same cycle.
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_vld && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/booth_operand_issuer.sv
// Purpose: queues operand pairs, drives an external Booth multiplier and returns tagged products.
// Latency: push into an empty, idle block -> res_valid rises MUL_CYCLES+2 edges after the push edge.
// Backpressure: in_ready drops with two entries queued; a result is held until res_ready, issue stalls meanwhile.
//
// Ports: clk, rst_a (async active-low); in_valid/in_ready/in_a/in_b/in_tag operand stream;
//        mul_a/mul_b/mul_load drive the multiplier, mul_out is its product;
//        res_valid/res_ready/res_product/res_tag result stream; busy = work pending.
module booth_operand_issuer
    import booth_pkg::*;
#(
    parameter int WIDTH      = BOOTH_WIDTH,
    parameter int MUL_CYCLES = BOOTH_MUL_CYCLES,
    parameter int TAG_W      = BOOTH_TAG_W
) (
    input  logic               clk,
    input  logic               rst_a,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_load,
    input  logic [2*WIDTH-1:0] mul_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
    output logic [TAG_W-1:0]   res_tag,
    output logic               busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam int ENT_W = TAG_W + 2 * WIDTH;

    issuer_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic               mul_load_q, mul_load_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] res_product_q, res_product_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;

    logic               fifo_pop;
    logic [ENT_W-1:0]   fifo_head;
    logic [1:0]         fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [TAG_W-1:0]   head_tag;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    booth_op_fifo #(
        .DW (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_a    (rst_a),
        .push_vld (in_valid),
        .push_dat ({in_tag, in_a, in_b}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {head_tag, head_a, head_b} = fifo_head;

    assign in_ready    = !fifo_full;
    assign busy        = (state_q != IDLE) || (fifo_count != 2'd0);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_load    = mul_load_q;
    assign res_valid   = res_valid_q;
    assign res_product = res_product_q;
    assign res_tag     = res_tag_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_load_d    = 1'b0;
        tag_d         = tag_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        res_tag_d     = res_tag_q;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    mul_a_d    = head_a;
                    mul_b_d    = head_b;
                    tag_d      = head_tag;
                    mul_load_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // The multiplier samples load=1 on this edge; start counting from it.
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    res_product_d = mul_out;
                    res_tag_d     = tag_q;
                    res_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    // Back-to-back issue: the next load pulse rides the handshake edge.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        mul_a_d    = head_a;
                        mul_b_d    = head_b;
                        tag_d      = head_tag;
                        mul_load_d = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_load_q    <= 1'b0;
            tag_q         <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            res_tag_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_load_q    <= mul_load_d;
            tag_q         <= tag_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
            res_tag_q     <= res_tag_d;
        end
    end

endmodule

// File: tb/tb_booth_operand_issuer.sv
// Purpose: self-checking bench for booth_operand_issuer with a behavioural Booth multiplier.
// Latency: n/a.
// Backpressure: exercises both in_ready and res_ready stalls.
module tb_booth_operand_issuer;

    localparam int W  = 32;
    localparam int MC = 33;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_a;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [TW-1:0]   in_tag;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_load;
    logic [2*W-1:0]  mul_out;
    logic            res_valid;
    logic            res_ready;
    logic [2*W-1:0]  res_product;
    logic [TW-1:0]   res_tag;
    logic            busy;

    booth_operand_issuer #(
        .WIDTH      (W),
        .MUL_CYCLES (MC),
        .TAG_W      (TW)
    ) dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_load    (mul_load),
        .mul_out     (mul_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_tag     (res_tag),
        .busy        (busy)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural multiplier: output is garbage while iterating and becomes the
    // signed product of whatever a/b hold on its final iteration, so a/b must
    // stay stable for the whole run. Valid after the 33rd edge counting the load edge.
    int bm_k    = 0;
    bit bm_busy = 1'b0;
    always @(posedge clk) begin
        if (mul_load) begin
            bm_k    <= 1;
            bm_busy <= 1'b1;
            mul_out <= {$urandom, $urandom};
        end else if (bm_busy) begin
            if (bm_k == MC - 1) begin
                mul_out <= $signed(mul_a) * $signed(mul_b);
                bm_busy <= 1'b0;
            end else begin
                bm_k    <= bm_k + 1;
                mul_out <= {$urandom, $urandom};
            end
        end
    end

    // Reference model: every accepted pair must come back once, in order,
    // as {tag, signed product}.
    logic [TW+2*W-1:0] exp_q[$];
    logic [TW+2*W-1:0] res_log[$];
    int  push_cyc = 0;
    int  n_loads  = 0;
    bit  prev_load = 1'b0;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    always @(negedge clk) begin
        if (rst_a) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, ref_prod(in_a, in_b)});
                push_cyc = cyc + 1;
            end
            if (res_valid && res_ready) begin
                logic [TW+2*W-1:0] e;
                check_eq("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_product", res_product, e[2*W-1:0]);
                    check_eq("sb_tag", 64'(res_tag), 64'(e[TW+2*W-1:2*W]));
                end
                res_log.push_back({res_tag, res_product});
            end
            if (mul_load) begin
                n_loads++;
                check_eq("load_not_consecutive", 64'(prev_load), 64'd0);
                check_eq("load_vs_res_valid", 64'(res_valid), 64'd0);
            end
            prev_load = mul_load;
        end else begin
            prev_load = 1'b0;
        end
    end

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bit acc;
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        do begin
            acc = in_ready;
            @(posedge clk);
            #10;
            guard++;
        end while (!acc && guard < 500);
        in_valid = 1'b0;
        check_eq("push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mul_load) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, 64'(ok), 64'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #(100 * 60000);
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int loads0;
        logic [63:0] hold_prod;
        logic [3:0]  hold_tag;
        logic [31:0] ha, hb;

        rst_a     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        res_ready = 1'b0;
        #120;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_mul_a", 64'(mul_a), 64'd0);
        check_eq("rst_mul_b", 64'(mul_b), 64'd0);
        check_eq("rst_mul_load", 64'(mul_load), 64'd0);
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_res_product", res_product, 64'd0);
        check_eq("rst_res_tag", 64'(res_tag), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #10;

        // 1. single op, latency and single-cycle load pulse
        res_ready = 1'b1;
        loads0    = n_loads;
        push_op(32'd10, 32'd2, 4'd1);
        wait_res(ok);
        check_eq("t1_res_seen", 64'(ok), 64'd1);
        check_eq("t1_latency", 64'(cyc - push_cyc), 64'(MC + 2));
        check_eq("t1_product", res_product, 64'd20);
        check_eq("t1_tag", 64'(res_tag), 64'd1);
        check_eq("t1_one_load", 64'(n_loads - loads0), 64'd1);
        drain("t1_drain");

        // 2. three back-to-back pushes fill the FIFO
        res_log.delete();
        push_op(32'd14, 32'd5, 4'd2);
        push_op(32'd8,  32'd5, 4'd3);
        push_op(32'd15, 32'd9, 4'd4);
        check_eq("t2_in_ready_full", 64'(in_ready), 64'd0);
        check_eq("t2_busy", 64'(busy), 64'd1);
        drain("t2_drain");
        check_eq("t2_count", 64'(res_log.size()), 64'd3);
        if (res_log.size() == 3) begin
            check_eq("t2_r0", res_log[0], {4'd2, 64'd70});
            check_eq("t2_r1", res_log[1], {4'd3, 64'd40});
            check_eq("t2_r2", res_log[2], {4'd4, 64'd135});
        end

        // 3. result stall: product stable, no issue, then load on the handshake edge
        res_ready = 1'b0;
        push_op(32'd6, 32'd7, 4'd5);
        push_op(32'hFFFF_FFFB, 32'hFFFF_FFF7, 4'd6);
        wait_res(ok);
        check_eq("t3_res_seen", 64'(ok), 64'd1);
        hold_prod = res_product;
        hold_tag  = res_tag;
        check_eq("t3_product", hold_prod, 64'd42);
        loads0 = n_loads;
        repeat (10) begin
            @(negedge clk);
            check_eq("t3_stable_product", res_product, hold_prod);
            check_eq("t3_stable_tag", 64'(res_tag), 64'(hold_tag));
            check_eq("t3_stable_valid", 64'(res_valid), 64'd1);
        end
        check_eq("t3_no_load", 64'(n_loads - loads0), 64'd0);
        @(posedge clk);
        #10;
        res_ready = 1'b1;
        @(posedge clk);
        #10;
        check_eq("t3_load_on_hs", 64'(mul_load), 64'd1);
        check_eq("t3_valid_dropped", 64'(res_valid), 64'd0);
        drain("t3_drain");

        // 4. negative operand
        res_log.delete();
        push_op(32'hFFFF_FFFD, 32'd7, 4'd7);
        drain("t4_drain");
        check_eq("t4_count", 64'(res_log.size()), 64'd1);
        if (res_log.size() == 1) begin
            check_eq("t4_result", res_log[0], {4'd7, 64'hFFFF_FFFF_FFFF_FFEB});
        end

        // 5. reset in the middle of an iteration
        push_op(32'd100, 32'd100, 4'd8);
        push_op(32'd3, 32'd3, 4'd9);
        wait_load(ok);
        check_eq("t5_load_seen", 64'(ok), 64'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #10;
        rst_a = 1'b0;
        #1;
        check_eq("t5_res_valid", 64'(res_valid), 64'd0);
        check_eq("t5_mul_load", 64'(mul_load), 64'd0);
        check_eq("t5_in_ready", 64'(in_ready), 64'd1);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_mul_a", 64'(mul_a), 64'd0);
        exp_q.delete();
        res_log.delete();
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #10;
        push_op(32'd15, 32'd9, 4'd10);
        drain("t5_drain");
        check_eq("t5_count", 64'(res_log.size()), 64'd1);
        if (res_log.size() == 1) begin
            check_eq("t5_result", res_log[0], {4'd10, 64'd135});
        end

        // 6. operand inputs wiggle while iterating; issued operands must not move
        res_log.delete();
        ha = 32'd1234567;
        hb = 32'hFFFF_FFA7;  // -89
        push_op(ha, hb, 4'd11);
        wait_load(ok);
        check_eq("t6_load_seen", 64'(ok), 64'd1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #10;
            in_a = $urandom;
            in_b = $urandom;
            @(negedge clk);
            if (res_valid) break;
            check_eq("t6_mul_a_held", 64'(mul_a), 64'(ha));
            check_eq("t6_mul_b_held", 64'(mul_b), 64'(hb));
        end
        drain("t6_drain");
        check_eq("t6_count", 64'(res_log.size()), 64'd1);
        if (res_log.size() == 1) begin
            check_eq("t6_result", res_log[0], {4'd11, -64'sd109876463});
        end

        // Random traffic with random result backpressure, checked by the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #10;
            in_valid  = ($urandom_range(0, 2) == 0);
            in_a      = pick_operand();
            in_b      = pick_operand();
            in_tag    = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #10;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
